// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared floating-point status type and output-buffer limits.
package fpnew_pkg;
  localparam int unsigned OUTBUF_MAX_DEPTH = 16;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
endpackage

// File: rtl/fpnew_opgroup_outbuf.sv
// fpnew_opgroup_outbuf: in-order output FIFO for an opgroup result stream.
// Optional sticky status accumulator enabled by FPNEW_OUTBUF_STATUS_ACC_EN.
module fpnew_opgroup_outbuf import fpnew_pkg::*; #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2,
  parameter type TagType = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [Width-1:0]           result_i,
  input  status_t                    status_i,
  input  logic                       extension_bit_i,
  input  TagType                     tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [Width-1:0]           result_o,
  output status_t                    status_o,
  output logic                       extension_bit_o,
  output TagType                     tag_o,
  output logic                       busy_o,
`ifdef FPNEW_OUTBUF_STATUS_ACC_EN
  output status_t                    acc_status_o,
`endif
  output logic [$clog2(Depth+1)-1:0] fill_o
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned FillW = $clog2(Depth+1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth-1);
  if (Depth < 1 || Depth > OUTBUF_MAX_DEPTH) begin : g_bad_depth
    $error("fpnew_opgroup_outbuf: Depth out of range");
  end
  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext_bit;
    TagType           tag;
  } entry_t;
  entry_t           mem_q [Depth];
  entry_t           head;
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [FillW-1:0] fill_q;
  logic             push, pop, discard;
  assign in_ready_o  = fill_q != FillW'(Depth);
  assign out_valid_o = fill_q != '0;
  assign busy_o      = out_valid_o;
  assign fill_o      = fill_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign discard     = clr_i | flush_i;
  assign head            = mem_q[rd_q];
  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.ext_bit;
  assign tag_o           = head.tag;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q   <= '0;
      wr_q   <= '0;
      fill_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (discard) begin
      rd_q   <= '0;
      wr_q   <= '0;
      fill_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= '{result: result_i, status: status_i, ext_bit: extension_bit_i, tag: tag_i};
        wr_q        <= wr_q == LastPtr ? '0 : wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q == LastPtr ? '0 : rd_q + 1'b1;
      fill_q <= fill_q + FillW'(push) - FillW'(pop);
    end
  end
`ifdef FPNEW_OUTBUF_STATUS_ACC_EN
  status_t acc_q;
  assign acc_status_o = acc_q;
  // A pop cancelled by flush never leaves the buffer, so it is not accumulated.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (pop && !flush_i) acc_q <= status_t'(acc_q | head.status);
  end
`endif
endmodule

// File: tb/tb_fpnew_opgroup_outbuf.sv
// tb_fpnew_opgroup_outbuf: directed and randomized checks of the output buffer against a queue model.
module tb_fpnew_opgroup_outbuf;
  import fpnew_pkg::*;
  typedef logic [3:0] tag_t;
  logic clk = 0, rst_n = 0, clr = 0, flush = 0;
  always #5 clk = ~clk;
  logic iv2 = 0, rdy2 = 0, ext2 = 0, ir2, ov2, eo2, busy2;
  logic [31:0] res2 = '0, ro2;
  status_t st2 = '0, so2;
  tag_t tag2 = '0, to2;
  logic [1:0] fill2;
  logic iv3 = 0, rdy3 = 0, ext3 = 0, ir3, ov3, eo3, busy3;
  logic [31:0] res3 = '0, ro3;
  status_t st3 = '0, so3;
  tag_t tag3 = '0, to3;
  logic [1:0] fill3;
`ifdef FPNEW_OUTBUF_STATUS_ACC_EN
  status_t acc2, acc3;
`endif
  int n_cmp = 0, n_err = 0;
  fpnew_opgroup_outbuf #(.Width(32), .Depth(2), .TagType(tag_t)) d2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .flush_i(flush),
    .in_valid_i(iv2), .in_ready_o(ir2), .result_i(res2), .status_i(st2),
    .extension_bit_i(ext2), .tag_i(tag2), .out_valid_o(ov2), .out_ready_i(rdy2),
    .result_o(ro2), .status_o(so2), .extension_bit_o(eo2), .tag_o(to2), .busy_o(busy2),
`ifdef FPNEW_OUTBUF_STATUS_ACC_EN
    .acc_status_o(acc2),
`endif
    .fill_o(fill2));
  fpnew_opgroup_outbuf #(.Width(32), .Depth(3), .TagType(tag_t)) d3 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .flush_i(flush),
    .in_valid_i(iv3), .in_ready_o(ir3), .result_i(res3), .status_i(st3),
    .extension_bit_i(ext3), .tag_i(tag3), .out_valid_o(ov3), .out_ready_i(rdy3),
    .result_o(ro3), .status_o(so3), .extension_bit_o(eo3), .tag_o(to3), .busy_o(busy3),
`ifdef FPNEW_OUTBUF_STATUS_ACC_EN
    .acc_status_o(acc3),
`endif
    .fill_o(fill3));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #2;
    n_cmp++; if ({ov2, busy2, ir2, fill2} !== 5'b00100) begin n_err++; $display("FAIL reset_d2 got ov/busy/ir/fill=%b want 00100", {ov2, busy2, ir2, fill2}); end
    n_cmp++; if ({ov3, busy3, ir3, fill3} !== 5'b00100) begin n_err++; $display("FAIL reset_d3 got ov/busy/ir/fill=%b want 00100", {ov3, busy3, ir3, fill3}); end
    n_cmp++; if (ro2 !== 32'h0) begin n_err++; $display("FAIL reset_payload got %h want 0", ro2); end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask
  task automatic test_single_push();
    iv2 = 1; res2 = 32'h3F800000; tag2 = 4'd1;
    step();
    iv2 = 0;
    n_cmp++; if (ov2 !== 1'b1 || busy2 !== 1'b1) begin n_err++; $display("FAIL single_valid got ov=%b busy=%b want 1 1", ov2, busy2); end
    n_cmp++; if (ro2 !== 32'h3F800000) begin n_err++; $display("FAIL single_result got %h want 3f800000", ro2); end
    n_cmp++; if (to2 !== 4'd1 || fill2 !== 2'd1) begin n_err++; $display("FAIL single_tag_fill got tag=%0d fill=%0d want 1 1", to2, fill2); end
    rdy2 = 1;
    step();
    rdy2 = 0;
    n_cmp++; if (fill2 !== 2'd0 || ov2 !== 1'b0) begin n_err++; $display("FAIL single_drain got fill=%0d ov=%b want 0 0", fill2, ov2); end
  endtask
  task automatic test_backpressure();
    rdy2 = 0; iv2 = 1;
    for (int i = 0; i < 3; i++) begin
      tag2 = tag_t'(2 + i); res2 = 32'hA000_0000 + i;
      step();
      n_cmp++; if (ir2 !== (i == 0) || fill2 !== 2'(i == 0 ? 1 : 2)) begin n_err++; $display("FAIL bp_push%0d got ir=%b fill=%0d want ir=%b fill=%0d", i, ir2, fill2, i == 0, i == 0 ? 1 : 2); end
    end
    iv2 = 0;
    n_cmp++; if (to2 !== 4'd2 || ro2 !== 32'hA000_0000) begin n_err++; $display("FAIL bp_head_stable got tag=%0d res=%h want 2 a0000000", to2, ro2); end
    rdy2 = 1;
    step();
    n_cmp++; if (to2 !== 4'd3 || ro2 !== 32'hA000_0001 || fill2 !== 2'd1) begin n_err++; $display("FAIL bp_second got tag=%0d res=%h fill=%0d want 3 a0000001 1", to2, ro2, fill2); end
    step();
    rdy2 = 0;
    n_cmp++; if (fill2 !== 2'd0 || ov2 !== 1'b0) begin n_err++; $display("FAIL bp_third_absent got fill=%0d ov=%b want 0 0", fill2, ov2); end
  endtask
  task automatic test_wrap();
    rdy3 = 1; iv3 = 1;
    for (int i = 0; i < 10; i++) begin
      tag3 = tag_t'(i); res3 = 32'h100 + i;
      step();
      n_cmp++; if (ov3 !== 1'b1 || to3 !== tag_t'(i) || ro3 !== 32'h100 + i || fill3 !== 2'd1) begin n_err++; $display("FAIL wrap_item%0d got ov=%b tag=%0d res=%h fill=%0d want 1 %0d %h 1", i, ov3, to3, ro3, fill3, i, 32'h100 + i); end
    end
    iv3 = 0;
    step();
    rdy3 = 0;
    n_cmp++; if (fill3 !== 2'd0 || ov3 !== 1'b0) begin n_err++; $display("FAIL wrap_end got fill=%0d ov=%b want 0 0", fill3, ov3); end
  endtask
  task automatic test_flush();
    iv2 = 1; rdy2 = 0;
    step();
    step();
    n_cmp++; if (fill2 !== 2'd2) begin n_err++; $display("FAIL flush_prefill got %0d want 2", fill2); end
    rdy2 = 1; flush = 1; tag2 = 4'd9;
    step();
    flush = 0; iv2 = 0;
    n_cmp++; if (fill2 !== 2'd0 || ov2 !== 1'b0 || ir2 !== 1'b1) begin n_err++; $display("FAIL flush_clear got fill=%0d ov=%b ir=%b want 0 0 1", fill2, ov2, ir2); end
    step();
    rdy2 = 0;
    n_cmp++; if (ov2 !== 1'b0 || fill2 !== 2'd0) begin n_err++; $display("FAIL flush_push_absent got ov=%b fill=%0d want 0 0", ov2, fill2); end
  endtask
`ifdef FPNEW_OUTBUF_STATUS_ACC_EN
  task automatic test_acc();
    clr = 1;
    step();
    clr = 0; iv2 = 1; rdy2 = 0; st2 = status_t'(5'b00001);
    step();
    st2 = status_t'(5'b10000);
    step();
    iv2 = 0; st2 = '0;
    n_cmp++; if (acc2 !== status_t'(5'b00000)) begin n_err++; $display("FAIL acc_before_pop got %b want 00000", acc2); end
    rdy2 = 1;
    step();
    n_cmp++; if (acc2 !== status_t'(5'b00001)) begin n_err++; $display("FAIL acc_first got %b want 00001", acc2); end
    step();
    rdy2 = 0;
    n_cmp++; if (acc2 !== status_t'(5'b10001)) begin n_err++; $display("FAIL acc_sticky got %b want 10001", acc2); end
    clr = 1;
    step();
    clr = 0;
    n_cmp++; if (acc2 !== status_t'(5'b00000)) begin n_err++; $display("FAIL acc_clr got %b want 00000", acc2); end
  endtask
`endif
  task automatic test_random();
    logic [41:0] q[$];
    logic [41:0] e;
    bit do_push, do_pop, do_flush;
    for (int c = 0; c < 400; c++) begin
      iv3 = 1'($urandom); rdy3 = 1'($urandom); flush = ($urandom % 20) == 0;
      res3 = $urandom; st3 = status_t'($urandom); ext3 = 1'($urandom); tag3 = tag_t'($urandom);
      do_push = iv3 && q.size() < 3;
      do_pop = rdy3 && q.size() > 0;
      do_flush = flush;
      e = {res3, st3, ext3, tag3};
      step();
      if (do_flush) q = {};
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
      end
      n_cmp++; if (fill3 !== 2'(q.size()) || ov3 !== (q.size() != 0) || ir3 !== (q.size() != 3) || busy3 !== (q.size() != 0)) begin n_err++; $display("FAIL rand_ctrl c=%0d got fill=%0d ov=%b ir=%b busy=%b want fill=%0d", c, fill3, ov3, ir3, busy3, q.size()); end
      if (q.size() != 0) begin
        n_cmp++; if ({ro3, so3, eo3, to3} !== q[0]) begin n_err++; $display("FAIL rand_head c=%0d got %h want %h", c, {ro3, so3, eo3, to3}, q[0]); end
      end
    end
    iv3 = 0; rdy3 = 0; flush = 0;
  endtask
  task automatic test_async_reset();
    iv2 = 1; rdy2 = 0;
    step();
    step();
    iv2 = 0;
    n_cmp++; if (fill2 !== 2'd2 || ir2 !== 1'b0) begin n_err++; $display("FAIL arst_prefill got fill=%0d ir=%b want 2 0", fill2, ir2); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (ov2 !== 1'b0 || ir2 !== 1'b1 || fill2 !== 2'd0 || busy2 !== 1'b0) begin n_err++; $display("FAIL arst_async got ov=%b ir=%b fill=%0d busy=%b want 0 1 0 0", ov2, ir2, fill2, busy2); end
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    test_reset();
    test_single_push();
    test_backpressure();
    test_wrap();
    test_flush();
`ifdef FPNEW_OUTBUF_STATUS_ACC_EN
    test_acc();
`endif
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fpnew_opgroup_outbuf.md
FPNEW_OPGROUP_OUTBUF -- requirements
Module: fpnew_opgroup_outbuf

Interface
REQ-001 The module SHALL have parameter Width, default 32, giving the result width in bits.
REQ-002 The module SHALL have parameter Depth, default 2, giving the number of buffer entries; legal values are 1 to 16.
REQ-003 The module SHALL have parameter TagType, default logic, giving the type of the opaque tag carried alongside each result.
REQ-004 The module SHALL have port clk_i, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-005 The module SHALL have port rst_ni, input, 1 bit, the reset; asynchronous, active-low.
REQ-006 The module SHALL have port clr_i, input, 1 bit, a synchronous clear.
REQ-007 The module SHALL have port flush_i, input, 1 bit, a synchronous flush.
REQ-008 The module SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1), the upstream handshake from the opgroup block output.
REQ-009 The module SHALL have ports result_i (input, Width), status_i (input, fpnew_pkg::status_t), extension_bit_i (input, 1) and tag_i (input, TagType), the upstream payload.
REQ-010 The module SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1), the downstream handshake.
REQ-011 The module SHALL have ports result_o, status_o, extension_bit_o and tag_o as outputs, mirroring the input payload types.
REQ-012 The module SHALL have port busy_o, output, 1 bit: high while any entry is held.
REQ-013 The module SHALL have port fill_o, output, $clog2(Depth+1) bits, giving the current entry count.
REQ-014 The module SHALL have port acc_status_o, output, fpnew_pkg::status_t, present only with the macro of REQ-030.

Function
REQ-015 The module SHALL implement an in-order FIFO of Depth entries; one entry holds result, status, ext_bit and tag.
- Push occurs on in_valid_i & in_ready_o.
- Pop occurs on out_valid_o & out_ready_i.
REQ-016 in_ready_o SHALL equal (fill != Depth) and SHALL have no combinational dependence on out_ready_i or in_valid_i.
REQ-017 out_valid_o SHALL equal (fill != 0); output payload SHALL be driven from registers at the read pointer (head entry).
REQ-018 Latency SHALL be exactly one cycle: a push at edge N makes out_valid_o high after edge N when the buffer was empty.
REQ-019 Simultaneous push and pop SHALL leave fill unchanged when 0 < fill < Depth.
- When full, push is blocked per REQ-016.
- When empty, no pop is possible.
REQ-020 Read and write pointers SHALL wrap from Depth-1 to 0, including for non-power-of-two Depth.
REQ-021 Held output payload SHALL stay stable while out_valid_o & !out_ready_i.
REQ-022 flush_i SHALL, at the next edge, set fill to 0 and both pointers to 0.
- Any same-cycle push or pop is discarded.
- The accumulator is unaffected.
REQ-023 clr_i SHALL act as flush_i and additionally zero the accumulator; clr_i has priority over all other events.
REQ-024 busy_o SHALL equal (fill != 0).
REQ-025 Payload of empty entries SHALL be don't-care; all control outputs SHALL be defined every cycle.

Reset
REQ-026 While rst_ni is low, the module SHALL hold fill, read pointer and write pointer at 0.
REQ-027 While rst_ni is low, out_valid_o and busy_o SHALL be 0, and in_ready_o SHALL be 1 (Depth>=1).
REQ-028 While rst_ni is low, acc_status_o SHALL be 0 and payload registers SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard all held entries immediately and asynchronously.

Configuration
REQ-030 With macro FPNEW_OUTBUF_STATUS_ACC_EN defined, the module SHALL OR each popped entry's status into acc_status_o at the pop edge.
- Sticky until clr_i or reset.
- A pop and clr_i in the same cycle yields 0.
REQ-031 Without FPNEW_OUTBUF_STATUS_ACC_EN, the acc_status_o port and its register SHALL not exist.

Structure
REQ-032 The entry struct typedef (result, status, ext_bit, tag) SHALL be local to the module, since it is parameterised by Width and TagType.
REQ-033 fpnew_pkg SHALL supply status_t and a constant OUTBUF_MAX_DEPTH = 16.
REQ-034 No sub-module SHALL be used; storage, pointers and counter are inline.

Verification
REQ-035 Reset then single push of result 32'h3F800000, tag 1 -> out_valid_o high the next cycle, result_o 32'h3F800000, fill_o 1.
REQ-036 Depth 2, out_ready_i low, three back-to-back pushes -> in_ready_o low after the second push, third push not accepted, fill_o 2.
REQ-037 Depth 3, continuous push/pop for 10 items with tags 0..9 -> output tag order 0..9, pointer wrap observed, no loss.
REQ-038 fill 2, flush_i pulsed together with a push -> next cycle fill_o 0, out_valid_o 0, pushed entry absent.
REQ-039 Macro defined: pop statuses 5'b00001 then 5'b10000 -> acc_status_o 5'b10001; clr_i -> 5'b00000.
REQ-040 rst_ni dropped asynchronously mid-cycle with fill 2 -> out_valid_o 0 without a clock edge, in_ready_o 1.
